gfx_cmd_sequencer: RTL

Command scheduler between the CPU's memory-mapped graphics writes and the two CP3 drawing engines (line engine, frame filler) exposed on the Riscv150 graphics ports. It buffers complete FILL/LINE commands in a FIFO and replays each one onto the engine ports as the exact valid/ready handshake sequence. It guarantees strict program order and at most one engine active at a time.

---
 rtl/gfx_cmd_sequencer_pkg.sv | 27 ++
 rtl/gfx_cmd_fifo.sv | 52 +++++
 rtl/gfx_cmd_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gfx_cmd_sequencer_pkg.sv
// rtl/gfx_cmd_sequencer_pkg.sv - shared constants, command word layout and FSM states
package gfx_cmd_sequencer_pkg;

  localparam int COORD_W   = 10;
  localparam int COLOR_W   = 32;
  localparam int CMD_W     = 1 + COLOR_W + 4 * COORD_W;

  // Command word layout, LSB first: y1, x1, y0, x0, color, fill flag
  localparam int Y1_LSB    = 0;
  localparam int X1_LSB    = Y1_LSB + COORD_W;
  localparam int Y0_LSB    = X1_LSB + COORD_W;
  localparam int X0_LSB    = Y0_LSB + COORD_W;
  localparam int COLOR_LSB = X0_LSB + COORD_W;
  localparam int FILL_BIT  = COLOR_LSB + COLOR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L_COLOR = 3'd1,
    S_L_X0    = 3'd2,
    S_L_Y0    = 3'd3,
    S_L_X1    = 3'd4,
    S_L_Y1    = 3'd5,
    S_L_TRIG  = 3'd6,
    S_F_FILL  = 3'd7
  } state_t;

endpackage

// File: rtl/gfx_cmd_fifo.sv
// rtl/gfx_cmd_fifo.sv - synchronous command FIFO with full/empty/count
module gfx_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gfx_cmd_sequencer.sv
// rtl/gfx_cmd_sequencer.sv - queues FILL/LINE commands and replays them onto the engine ports
module gfx_cmd_sequencer
  import gfx_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_fill,
  input  logic [31:0]        cmd_color,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               line_ready,
  input  logic               filler_ready,
  output logic [31:0]        line_color,
  output logic [COORD_W-1:0] line_point,
  output logic               line_color_valid,
  output logic               line_x0_valid,
  output logic               line_y0_valid,
  output logic               line_x1_valid,
  output logic               line_y1_valid,
  output logic               line_trigger,
  output logic [23:0]        filler_color,
  output logic               filler_valid,
  output logic               busy,
  output logic [PTR_W:0]     fifo_count
);

  state_t           state_q, state_d;
  logic [CMD_W-1:0] cmd_q;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;

  // Ready is held low during reset so no command slips in before release
  assign cmd_ready = rst & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

  gfx_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_is_fill, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State and the command being replayed; reset abandons any in-flight command
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= fifo_rdata;
    end
  end

  // Next state and strobes decode from registered state only; ready only steers advance
  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    line_color       = '0;
    line_point       = '0;
    line_color_valid = 1'b0;
    line_x0_valid    = 1'b0;
    line_y0_valid    = 1'b0;
    line_x1_valid    = 1'b0;
    line_y1_valid    = 1'b0;
    line_trigger     = 1'b0;
    filler_color     = '0;
    filler_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = fifo_rdata[FILL_BIT] ? S_F_FILL : S_L_COLOR;
        end
      end
      S_L_COLOR: begin
        line_color       = cmd_q[COLOR_LSB +: 32];
        line_color_valid = 1'b1;
        if (line_ready) state_d = S_L_X0;
      end
      S_L_X0: begin
        line_color    = cmd_q[COLOR_LSB +: 32];
        line_point    = cmd_q[X0_LSB +: COORD_W];
        line_x0_valid = 1'b1;
        if (line_ready) state_d = S_L_Y0;
      end
      S_L_Y0: begin
        line_color    = cmd_q[COLOR_LSB +: 32];
        line_point    = cmd_q[Y0_LSB +: COORD_W];
        line_y0_valid = 1'b1;
        if (line_ready) state_d = S_L_X1;
      end
      S_L_X1: begin
        line_color    = cmd_q[COLOR_LSB +: 32];
        line_point    = cmd_q[X1_LSB +: COORD_W];
        line_x1_valid = 1'b1;
        if (line_ready) state_d = S_L_Y1;
      end
      S_L_Y1: begin
        line_color    = cmd_q[COLOR_LSB +: 32];
        line_point    = cmd_q[Y1_LSB +: COORD_W];
        line_y1_valid = 1'b1;
        if (line_ready) state_d = S_L_TRIG;
      end
      S_L_TRIG: begin
        line_color   = cmd_q[COLOR_LSB +: 32];
        line_trigger = 1'b1;
        if (line_ready) state_d = S_IDLE;
      end
      S_F_FILL: begin
        filler_color = cmd_q[COLOR_LSB +: 24];
        filler_valid = 1'b1;
        if (filler_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
